// File: rtl/trap_ctrl.sv
// Trap arbitration and sequencing for the write-back boundary: picks one
// exception or interrupt, resolves target privilege, and handshakes with the CPU FSM.
module trap_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       statu_cpu,
  input  logic [1:0]       msu,
  input  logic             mie,
  input  logic             sie,
  input  logic [31:0]      mideleg,
  input  logic [31:0]      medeleg,
  input  logic             meip,
  input  logic             seip,
  input  logic             mtip,
  input  logic             stip,
  input  logic             msip,
  input  logic             ssip,
  input  logic             meie,
  input  logic             seie,
  input  logic             mtie,
  input  logic             stie,
  input  logic             msie,
  input  logic             ssie,
  input  logic             exc_vld,
  input  logic [4:0]       exc_code,
  input  logic [31:0]      exc_tval,
  output logic             trap_req,
  output logic [31:0]      cause,
  output logic [31:0]      tval,
  output logic [1:0]       priv_d,
  output logic [CNT_W-1:0] exc_cnt,
  output logic [CNT_W-1:0] int_cnt
);
  localparam logic [3:0] ST_WB  = 4'b0011;
  localparam logic [3:0] ST_EXC = 4'b1111;
  localparam logic [1:0] PRV_M  = 2'b11;
  localparam logic [1:0] PRV_S  = 2'b01;
  localparam logic [1:0] PRV_U  = 2'b00;

  // Index 5 is the highest priority: MEI > MSI > MTI > SEI > SSI > STI.
  localparam logic [5:0][3:0] INT_CODE = {4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_e;

  state_e           state_q, state_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      tval_q, tval_d;
  logic [1:0]       priv_q, priv_q_d;
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;
  logic [CNT_W-1:0] int_cnt_q, int_cnt_d;

  logic [5:0] cand;
  logic       int_hit;
  logic [3:0] int_code;
  logic [1:0] int_priv;
  logic       tgt_s;
  logic       takeable;

  assign cand = {meip & meie, msip & msie, mtip & mtie,
                 seip & seie, ssip & ssie, stip & stie};

  // Ascending scan so the highest takeable candidate overwrites lower ones;
  // a blocked higher candidate never masks a takeable lower one.
  always_comb begin
    int_hit  = 1'b0;
    int_code = 4'd0;
    int_priv = PRV_M;
    tgt_s    = 1'b0;
    takeable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tgt_s    = mideleg[{1'b0, INT_CODE[i]}] && (msu != PRV_M);
      takeable = tgt_s ? ((msu == PRV_U) || ((msu == PRV_S) && sie))
                       : ((msu != PRV_M) || mie);
      if (cand[i] && takeable) begin
        int_hit  = 1'b1;
        int_code = INT_CODE[i];
        int_priv = tgt_s ? PRV_S : PRV_M;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    priv_q_d  = priv_q;
    exc_cnt_d = exc_cnt_q;
    int_cnt_d = int_cnt_q;
    case (state_q)
      IDLE: begin
        if (statu_cpu == ST_WB) begin
          if (exc_vld) begin
            cause_d  = {27'b0, exc_code};
            tval_d   = exc_tval;
            priv_q_d = (medeleg[exc_code] && (msu != PRV_M)) ? PRV_S : PRV_M;
            state_d  = PEND;
          end else if (int_hit) begin
            cause_d  = {1'b1, 27'b0, int_code};
            tval_d   = 32'd0;
            priv_q_d = int_priv;
            state_d  = PEND;
          end
        end
      end
      PEND: begin
        if (statu_cpu == ST_EXC) begin
          state_d = HOLD;
          if (cause_q[31]) begin
            if (int_cnt_q != '1) int_cnt_d = int_cnt_q + 1'b1;
          end else begin
            if (exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + 1'b1;
          end
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cause_q   <= 32'd0;
      tval_q    <= 32'd0;
      priv_q    <= PRV_M;
      exc_cnt_q <= '0;
      int_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      priv_q    <= priv_q_d;
      exc_cnt_q <= exc_cnt_d;
      int_cnt_q <= int_cnt_d;
    end
  end

  assign trap_req = (state_q == PEND);
  assign cause    = cause_q;
  assign tval     = tval_q;
  assign priv_d   = priv_q;
  assign exc_cnt  = exc_cnt_q;
  assign int_cnt  = int_cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed plus randomized bench for trap_ctrl, checked against a
// rule-level reference model of trap selection, privilege and counters.
module tb_trap_ctrl;
  localparam int CNT_W = 2;
  localparam logic [3:0] S_IF0 = 4'b0000, S_WB = 4'b0011, S_EXC = 4'b1111;

  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] statu_cpu;
  logic [1:0] msu;
  logic mie, sie;
  logic [31:0] mideleg, medeleg;
  logic meip, seip, mtip, stip, msip, ssip;
  logic meie, seie, mtie, stie, msie, ssie;
  logic exc_vld;
  logic [4:0] exc_code;
  logic [31:0] exc_tval;
  logic trap_req;
  logic [31:0] cause, tval;
  logic [1:0] priv_d;
  logic [CNT_W-1:0] exc_cnt, int_cnt;

  int n_assert = 0, n_fail = 0;
  logic [31:0] m_cause, m_tval;
  logic [1:0] m_priv;
  int m_exc, m_int;

  trap_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .statu_cpu(statu_cpu), .msu(msu), .mie(mie), .sie(sie),
    .mideleg(mideleg), .medeleg(medeleg),
    .meip(meip), .seip(seip), .mtip(mtip), .stip(stip), .msip(msip), .ssip(ssip),
    .meie(meie), .seie(seie), .mtie(mtie), .stie(stie), .msie(msie), .ssie(ssie),
    .exc_vld(exc_vld), .exc_code(exc_code), .exc_tval(exc_tval),
    .trap_req(trap_req), .cause(cause), .tval(tval), .priv_d(priv_d),
    .exc_cnt(exc_cnt), .int_cnt(int_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    statu_cpu = S_IF0; msu = 2'b11; mie = 0; sie = 0; mideleg = 0; medeleg = 0;
    {meip, seip, mtip, stip, msip, ssip} = '0;
    {meie, seie, mtie, stie, msie, ssie} = '0;
    exc_vld = 0; exc_code = 0; exc_tval = 0;
  endtask

  function automatic int sat(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk_out(input string tag);
    chk({tag, ".cause"}, 64'(cause), 64'(m_cause));
    chk({tag, ".tval"}, 64'(tval), 64'(m_tval));
    chk({tag, ".priv"}, 64'(priv_d), 64'(m_priv));
  endtask

  // Reference model: given current inputs, decide whether a trap is taken and its fields.
  function automatic bit model_eval(output logic [31:0] c, output logic [31:0] t,
                                    output logic [1:0] p);
    int ord [6] = '{11, 3, 7, 9, 1, 5};
    logic [15:0] pend, en;
    int dest;
    bit ok;
    c = 0; t = 0; p = 2'b11;
    if (exc_vld) begin
      c = {27'b0, exc_code};
      t = exc_tval;
      p = (medeleg[exc_code] && msu != 2'b11) ? 2'b01 : 2'b11;
      return 1;
    end
    pend = '0; en = '0;
    pend[11] = meip; pend[9] = seip; pend[7] = mtip; pend[5] = stip; pend[3] = msip; pend[1] = ssip;
    en[11] = meie; en[9] = seie; en[7] = mtie; en[5] = stie; en[3] = msie; en[1] = ssie;
    foreach (ord[k]) begin
      if (pend[ord[k]] && en[ord[k]]) begin
        dest = (mideleg[ord[k]] && msu != 2'b11) ? 1 : 3;
        if (dest == 3) ok = (msu != 2'b11) || mie;
        else           ok = (msu == 2'b00) || (msu == 2'b01 && sie);
        if (ok) begin
          c = 32'h8000_0000 | 32'(ord[k]);
          t = 0;
          p = 2'(dest);
          return 1;
        end
      end
    end
    return 0;
  endfunction

  // Present a wb boundary and check the response one edge later.
  task automatic boundary(input string tag, output bit hit);
    logic [31:0] c, t;
    logic [1:0] p;
    hit = model_eval(c, t, p);
    if (hit) begin m_cause = c; m_tval = t; m_priv = p; end
    statu_cpu = S_WB;
    step();
    statu_cpu = S_IF0;
    chk({tag, ".req"}, 64'(trap_req), 64'(hit));
    chk_out(tag);
  endtask

  // CPU reaches exc: request drops, counter bumps; then HOLD back to IDLE.
  task automatic take(input string tag);
    statu_cpu = S_EXC;
    step();
    if (m_cause[31]) m_int++; else m_exc++;
    chk({tag, ".req_drop"}, 64'(trap_req), 64'd0);
    chk_out({tag, ".exc"});
    chk({tag, ".int_cnt"}, 64'(int_cnt), 64'(sat(m_int)));
    chk({tag, ".exc_cnt"}, 64'(exc_cnt), 64'(sat(m_exc)));
    statu_cpu = S_WB;   // wb during HOLD must not be evaluated
    exc_vld = 1; exc_code = 5'd3;
    step();
    statu_cpu = S_IF0; exc_vld = 0;
    chk({tag, ".hold"}, 64'(trap_req), 64'd0);
    chk_out({tag, ".hold"});
  endtask

  task automatic do_reset();
    rst = 0; #2; rst = 1;
    m_cause = 0; m_tval = 0; m_priv = 2'b11; m_exc = 0; m_int = 0;
  endtask

  initial begin
    bit hit;
    clear_in();
    m_cause = 0; m_tval = 0; m_priv = 2'b11; m_exc = 0; m_int = 0;
    step(); step();
    chk("rst.req", 64'(trap_req), 64'd0);
    chk_out("rst");
    chk("rst.cnt", 64'({exc_cnt, int_cnt}), 64'd0);
    rst = 1;
    step();

    // Priority among M interrupts, then a long PEND with inputs wiggling.
    msu = 2'b00; meip = 1; meie = 1; msip = 1; msie = 1; mtip = 1; mtie = 1;
    boundary("prio", hit);
    chk("prio.cause_lit", 64'(cause), 64'h8000_000B);
    for (int i = 0; i < 5; i++) begin
      statu_cpu = (i % 2) ? S_WB : S_IF0;
      exc_vld = 1; exc_code = 5'd13; exc_tval = 32'hDEAD;
      step();
      chk("pend.req", 64'(trap_req), 64'd1);
      chk_out("pend");
    end
    exc_vld = 0; statu_cpu = S_IF0;
    take("prio");
    clear_in();

    // S interrupt not takeable at M, then taken at S.
    msu = 2'b11; mie = 0; seip = 1; seie = 1; mideleg = 32'h200;
    boundary("s_at_m", hit);
    chk("s_at_m.req_lit", 64'(trap_req), 64'd0);
    msu = 2'b01; sie = 1;
    boundary("s_at_s", hit);
    chk("s_at_s.cause_lit", 64'(cause), 64'h8000_0009);
    chk("s_at_s.priv_lit", 64'(priv_d), 64'd1);
    take("s_at_s");
    clear_in();

    // Delegated exception at U, not delegated at M.
    msu = 2'b00; exc_vld = 1; exc_code = 5'd8; exc_tval = 32'h1234; medeleg = 32'h100;
    boundary("deleg_u", hit);
    chk("deleg_u.priv_lit", 64'(priv_d), 64'd1);
    take("deleg_u");
    exc_vld = 1; msu = 2'b11;
    boundary("deleg_m", hit);
    chk("deleg_m.priv_lit", 64'(priv_d), 64'd3);
    take("deleg_m");
    clear_in();

    // Exception beats interrupt; interrupt taken at the following boundary.
    msu = 2'b00; exc_vld = 1; exc_code = 5'd2; mtip = 1; mtie = 1;
    boundary("exc_win", hit);
    chk("exc_win.cause_lit", 64'(cause), 64'd2);
    take("exc_win");
    exc_vld = 0;
    boundary("int_next", hit);
    chk("int_next.cause_lit", 64'(cause), 64'h8000_0007);
    take("int_next");
    boundary("sat", hit);
    take("sat");
    boundary("sat2", hit);
    take("sat2");
    chk("sat.int_lit", 64'(int_cnt), 64'd3);

    // Asynchronous reset while PEND.
    msu = 2'b00; exc_vld = 1; exc_code = 5'd5; exc_tval = 32'h77;
    boundary("pre_rst", hit);
    #3 rst = 0;
    #1;
    chk("async.req", 64'(trap_req), 64'd0);
    chk("async.priv", 64'(priv_d), 64'd3);
    chk("async.cause", 64'(cause), 64'd0);
    #1 rst = 1;
    m_cause = 0; m_tval = 0; m_priv = 2'b11; m_exc = 0; m_int = 0;
    clear_in();
    step();

    // Randomized boundaries against the model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 11) == 0) do_reset();
      case ($urandom_range(0, 2))
        0: msu = 2'b00;
        1: msu = 2'b01;
        default: msu = 2'b11;
      endcase
      mie = 1'($urandom); sie = 1'($urandom);
      mideleg = $urandom; medeleg = $urandom;
      {meip, seip, mtip, stip, msip, ssip} = 6'($urandom);
      {meie, seie, mtie, stie, msie, ssie} = 6'($urandom);
      exc_vld = ($urandom_range(0, 3) == 0);
      exc_code = 5'($urandom_range(0, 15));
      exc_tval = $urandom;
      boundary("rnd", hit);
      exc_vld = 0;
      if (hit) begin
        for (int w = $urandom_range(0, 2); w > 0; w--) begin
          step();
          chk("rnd.wait", 64'(trap_req), 64'd1);
        end
        take("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap arbitration and sequencing controller for the PRV332SV0 core, placed beside the CSR unit. At each write-back boundary it evaluates:
- the synchronous exception reported by the pipeline;
- the pending/enabled interrupt bits and delegation registers exported by the CSR unit.

It picks one trap by fixed priority, resolves the target privilege, and holds `cause`/`tval`/`priv_d` stable while requesting the CPU state machine to enter the exception state. It also keeps saturating trap counters for debug.

## Interface
Parameters:
- `CNT_W`, 16: width of the trap statistics counters.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `statu_cpu`  in  4  CPU state: if0=4'b0000, wb=4'b0011, exc=4'b1111.
- `msu`  in  2  current privilege: M=11, S=01, U=00.
- `mie`, `sie`  in  1 each  mstatus global interrupt enables.
- `mideleg`, `medeleg`  in  32 each  delegation registers.
- `meip`, `seip`, `mtip`, `stip`, `msip`, `ssip`  in  1 each  pending bits.
- `meie`, `seie`, `mtie`, `stie`, `msie`, `ssie`  in  1 each  enable bits.
- `exc_vld`  in  1  synchronous exception present on the instruction in wb.
- `exc_code`  in  5  exception code, 0..15.
- `exc_tval`  in  32  exception value.
- `trap_req`  out  1  request to the CPU to enter exc.
- `cause`  out  32  registered trap cause.
- `tval`  out  32  registered trap value.
- `priv_d`  out  2  registered destination privilege.
- `exc_cnt`, `int_cnt`  out  CNT_W each  saturating counts of exceptions and interrupts taken.

## Operation
- **States:**
  - IDLE: evaluating.
  - PEND: `trap_req`=1, waiting for the CPU to reach exc.
  - HOLD: one-cycle holdoff after a trap is taken.
- **IDLE, on an edge where `statu_cpu`==wb:**
  - If `exc_vld`, latch the exception.
  - Else, if an interrupt is takeable, latch the highest-priority one.
  - Either way, go to PEND. Otherwise stay in IDLE.
  - Exceptions always win over interrupts.
- **Interrupt candidate i:** pending_i & enable_i.
- **Interrupt priority:** MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5).
  - Choose the highest-priority candidate that is takeable. A blocked higher candidate does not mask a takeable lower one.
- **Interrupt target:**
  - S if `mideleg[i]`=1 and `msu`!=M; otherwise M.
  - Target M is takeable if `msu`!=M, or if `msu`==M and `mie`=1.
  - Target S is takeable if `msu`==U, or if `msu`==S and `sie`=1. It is never takeable at M.
- **Interrupt latch:** `cause`={1'b1,27'b0,code[3:0]}, `tval`=0.
- **Exception latch:** `cause`={27'b0,`exc_code`}, `tval`=`exc_tval`.
  - `priv_d`=S if `medeleg[exc_code]`=1 and `msu`!=M; otherwise M.
- **PEND:**
  - `trap_req`=1. `cause`/`tval`/`priv_d` are frozen; no re-evaluation.
  - On an edge where `statu_cpu`==exc, go to HOLD. Increment `exc_cnt` or `int_cnt` (saturate at all-ones).
- **HOLD:** `trap_req`=0, outputs still held. Go to IDLE next edge. A wb seen in HOLD is not evaluated.
- **Ignored in PEND:** new exceptions or interrupt changes. Pending bits are level; an interrupt still asserted is re-evaluated at the next wb.
- **Reset, asserted at any time:** the state machine returns to IDLE immediately and asynchronously. Any in-flight trap is dropped.

## Timing
- **Reset values:** `trap_req`=0, `cause`=0, `tval`=0, `priv_d`=2'b11, `exc_cnt`=0, `int_cnt`=0, state IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- **Latency:** a wb cycle at edge N gives `trap_req`=1 and valid `cause`/`tval`/`priv_d` from N+1.
- `trap_req` remains 1 until the first edge that samples `statu_cpu`==exc, and drops after that edge.
- `cause`/`tval`/`priv_d` stay valid through the entire exc cycle and the HOLD cycle.
- Minimum spacing between two trap requests: PEND, HOLD, then the next wb.
- If `exc_vld` and an interrupt coincide, the exception is latched. The interrupt remains pending for the next boundary.

## Test plan
- **Priority:** `msu`=U; meip, msip, mtip set and enabled; `mideleg`=0; wb → `trap_req`=1 next cycle, `cause`=32'h8000000B, `priv_d`=11, `tval`=0.
- **S interrupts at M:** `msu`=M, `mie`=0, seip/seie=1, `mideleg[9]`=1 → no `trap_req`. Then `msu`=S, `sie`=1, wb → `cause`=32'h80000009, `priv_d`=01.
- **Delegated exception:** `msu`=U, `exc_vld`=1, `exc_code`=8, `exc_tval`=32'h1234, `medeleg`=32'h100 → `cause`=8, `tval`=32'h1234, `priv_d`=01. Same at `msu`=M → `priv_d`=11.
- **Exception over interrupt:** `exc_vld` plus mtip/mtie=1 in the same wb → `cause`=2. After exc and HOLD, the next wb gives `cause`=32'h80000007.
- **Handshake and counters:** `statu_cpu` stays non-exc for 5 cycles → `trap_req` held, outputs frozen. Exc cycle → `trap_req`=0 next edge, `int_cnt`+1. With CNT_W=2 and 5 traps, the counter reads 3.
- **Reset in PEND:** drop `rst` low mid-cycle → `trap_req`=0 and `priv_d`=11 immediately, without waiting for an edge.
